// File: rtl/dram_axi_pkg.sv
// rtl/dram_axi_pkg.sv - shared AXI read-channel types and response codes
package dram_axi_pkg;

    localparam int R_DATA_WIDTH = 32;
    localparam int R_ID_WIDTH   = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [R_DATA_WIDTH-1:0] data;
        logic [R_ID_WIDTH-1:0]   id;
        logic [1:0]              resp;
        logic                    last;
    } r_beat_t;

endpackage

// File: rtl/axi_fifo_r.sv
// rtl/axi_fifo_r.sv - R-channel beat buffer with cut-through or store-and-forward release
module axi_fifo_r
    import dram_axi_pkg::*;
#(
    parameter int LOG_QUEUE_SIZE    = 2,
    parameter int DATA_WIDTH        = 32,
    parameter int TID_WIDTH         = 8,
    parameter int STORE_AND_FORWARD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_r_valid,
    output logic                    s_r_ready,
    input  logic [DATA_WIDTH-1:0]   s_r_data,
    input  logic [TID_WIDTH-1:0]    s_r_id,
    input  logic [1:0]              s_r_resp,
    input  logic                    s_r_last,
    output logic                    m_r_valid,
    input  logic                    m_r_ready,
    output logic [DATA_WIDTH-1:0]   m_r_data,
    output logic [TID_WIDTH-1:0]    m_r_id,
    output logic [1:0]              m_r_resp,
    output logic                    m_r_last,
    output logic [LOG_QUEUE_SIZE:0] beat_count,
    output logic [LOG_QUEUE_SIZE:0] burst_count,
    output logic                    saf_overflow
);

    localparam int N  = 1 << LOG_QUEUE_SIZE;
    localparam int PW = LOG_QUEUE_SIZE + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TID_WIDTH-1:0]  id;
        logic [1:0]            resp;
        logic                  last;
    } beat_t;

    beat_t           mem_q [N];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   burst_count_q, burst_count_d;
    logic            bypass_q, bypass_d;
    logic            saf_overflow_q, saf_overflow_d;

    logic            empty, full, push, pop, release_ok;
    beat_t           head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign head  = mem_q[rd_ptr_q[PW-2:0]];

    assign release_ok = (STORE_AND_FORWARD == 0) || (burst_count_q != '0) || bypass_q;

    assign s_r_ready = !full && !rst;
    assign m_r_valid = !empty && !rst && release_ok;
    assign push      = s_r_valid && s_r_ready;
    assign pop       = m_r_valid && m_r_ready;

    assign m_r_data  = empty ? '0 : head.data;
    assign m_r_id    = empty ? '0 : head.id;
    assign m_r_resp  = empty ? RESP_OKAY : head.resp;
    assign m_r_last  = empty ? 1'b0 : head.last;

    assign beat_count   = wr_ptr_q - rd_ptr_q;
    assign burst_count  = burst_count_q;
    assign saf_overflow = saf_overflow_q;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        burst_count_d  = burst_count_q;
        bypass_d       = bypass_q;
        saf_overflow_d = saf_overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push && s_r_last, pop && head.last})
            2'b10:   burst_count_d = burst_count_q + PW'(1);
            2'b01:   burst_count_d = burst_count_q - PW'(1);
            default: burst_count_d = burst_count_q;
        endcase

        // A full buffer with no complete burst can never release; fall back to cut-through.
        if (STORE_AND_FORWARD != 0) begin
            if (pop && head.last) bypass_d = 1'b0;
            if (full && (burst_count_q == '0)) begin
                bypass_d       = 1'b1;
                saf_overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            burst_count_q  <= '0;
            bypass_q       <= 1'b0;
            saf_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            burst_count_q  <= burst_count_d;
            bypass_q       <= bypass_d;
            saf_overflow_q <= saf_overflow_d;
        end
    end

    // Storage is not cleared by reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-2:0]] <= '{data: s_r_data, id: s_r_id, resp: s_r_resp, last: s_r_last};
        end
    end

endmodule

// File: tb/tb_axi_fifo_r.sv
// tb/tb_axi_fifo_r.sv - self-checking bench for axi_fifo_r, cut-through and store-and-forward instances
module tb_axi_fifo_r;
    import dram_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_valid, s_last, m_ready;
    logic [31:0] s_data;
    logic [7:0]  s_id;
    logic [1:0]  s_resp;

    logic        s_ready_w [2];
    logic        m_valid_w [2];
    logic        m_last_w  [2];
    logic        saf_w     [2];
    logic [31:0] m_data_w  [2];
    logic [7:0]  m_id_w    [2];
    logic [1:0]  m_resp_w  [2];
    logic [2:0]  bc_w      [2];
    logic [2:0]  brc_w     [2];

    axi_fifo_r #(.LOG_QUEUE_SIZE(2), .DATA_WIDTH(32), .TID_WIDTH(8), .STORE_AND_FORWARD(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_r_valid(s_valid), .s_r_ready(s_ready_w[0]), .s_r_data(s_data), .s_r_id(s_id),
        .s_r_resp(s_resp), .s_r_last(s_last),
        .m_r_valid(m_valid_w[0]), .m_r_ready(m_ready), .m_r_data(m_data_w[0]), .m_r_id(m_id_w[0]),
        .m_r_resp(m_resp_w[0]), .m_r_last(m_last_w[0]),
        .beat_count(bc_w[0]), .burst_count(brc_w[0]), .saf_overflow(saf_w[0])
    );

    axi_fifo_r #(.LOG_QUEUE_SIZE(2), .DATA_WIDTH(32), .TID_WIDTH(8), .STORE_AND_FORWARD(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_r_valid(s_valid), .s_r_ready(s_ready_w[1]), .s_r_data(s_data), .s_r_id(s_id),
        .s_r_resp(s_resp), .s_r_last(s_last),
        .m_r_valid(m_valid_w[1]), .m_r_ready(m_ready), .m_r_data(m_data_w[1]), .m_r_id(m_id_w[1]),
        .m_r_resp(m_resp_w[1]), .m_r_last(m_last_w[1]),
        .beat_count(bc_w[1]), .burst_count(brc_w[1]), .saf_overflow(saf_w[1])
    );

    int nchk = 0;
    int nerr = 0;

    r_beat_t mq0[$];
    r_beat_t mq1[$];
    bit      mbyp [2];
    bit      msaf [2];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: a queue of beats per instance; release and fallback rules applied to the queue directly.
    function automatic void model_cycle();
        r_beat_t q[$];
        r_beat_t eh;
        int      n, nl;
        bit      er, ev, pl, stuck;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) q = mq0; else q = mq1;
            n  = q.size();
            nl = 0;
            foreach (q[i]) if (q[i].last) nl++;
            er = !rst && (n < 4);
            ev = !rst && (n > 0) && (k == 0 || nl > 0 || mbyp[k]);
            eh = (n > 0) ? q[0] : '0;
            chk($sformatf("s_ready%0d", k), 64'(s_ready_w[k]), 64'(er));
            chk($sformatf("m_valid%0d", k), 64'(m_valid_w[k]), 64'(ev));
            chk($sformatf("m_data%0d", k),  64'(m_data_w[k]),  64'(eh.data));
            chk($sformatf("m_id%0d", k),    64'(m_id_w[k]),    64'(eh.id));
            chk($sformatf("m_resp%0d", k),  64'(m_resp_w[k]),  64'(eh.resp));
            chk($sformatf("m_last%0d", k),  64'(m_last_w[k]),  64'(eh.last));
            chk($sformatf("beat_count%0d", k),  64'(bc_w[k]),  64'(n));
            chk($sformatf("burst_count%0d", k), 64'(brc_w[k]), 64'(nl));
            chk($sformatf("saf_overflow%0d", k), 64'(saf_w[k]), 64'(msaf[k]));
            if (rst) begin
                q.delete();
                mbyp[k] = 1'b0;
                msaf[k] = 1'b0;
            end else begin
                pl    = 1'b0;
                stuck = (k == 1) && (n == 4) && (nl == 0);
                if (ev && m_ready) begin
                    pl = q[0].last;
                    void'(q.pop_front());
                end
                if (er && s_valid) q.push_back({s_data, s_id, s_resp, s_last});
                if (pl) mbyp[k] = 1'b0;
                if (stuck) begin
                    mbyp[k] = 1'b1;
                    msaf[k] = 1'b1;
                end
            end
            if (k == 0) mq0 = q; else mq1 = q;
        end
    endfunction

    task automatic drive(input logic r, input logic sv, input logic [31:0] d, input logic [7:0] id,
                         input logic l, input logic mr);
        rst     = r;
        s_valid = sv;
        s_data  = d;
        s_id    = id;
        s_resp  = 2'($urandom_range(0, 3));
        s_last  = l;
        m_ready = mr;
    endtask

    task automatic advance();
        #2;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic sv, input logic [31:0] d, input logic [7:0] id,
                        input logic l, input logic mr);
        drive(r, sv, d, id, l, mr);
        advance();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        sv;
        logic [31:0] d;
        logic        l;
        logic        ev;
        logic [31:0] edata;
        logic        elast;
        logic [2:0]  ebc;
        logic [2:0]  ebrc;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{sv: 1'b1, d: 32'hA0, l: 1'b0, ev: 1'b0, edata: 32'h0,  elast: 1'b0, ebc: 3'd0, ebrc: 3'd0};
        tbl[1] = '{sv: 1'b1, d: 32'hA1, l: 1'b0, ev: 1'b1, edata: 32'hA0, elast: 1'b0, ebc: 3'd1, ebrc: 3'd0};
        tbl[2] = '{sv: 1'b1, d: 32'hA2, l: 1'b1, ev: 1'b1, edata: 32'hA1, elast: 1'b0, ebc: 3'd1, ebrc: 3'd0};
        tbl[3] = '{sv: 1'b0, d: 32'h0,  l: 1'b0, ev: 1'b1, edata: 32'hA2, elast: 1'b1, ebc: 3'd1, ebrc: 3'd1};
        tbl[4] = '{sv: 1'b0, d: 32'h0,  l: 1'b0, ev: 1'b0, edata: 32'h0,  elast: 1'b0, ebc: 3'd0, ebrc: 3'd0};

        drive(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Cut-through 3-beat burst, consumer always ready
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, tbl[i].sv, tbl[i].d, 8'd5, tbl[i].l, 1'b1);
            #1;
            chk($sformatf("tbl%0d.m_valid", i), 64'(m_valid_w[0]), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.m_data", i),  64'(m_data_w[0]),  64'(tbl[i].edata));
            chk($sformatf("tbl%0d.m_last", i),  64'(m_last_w[0]),  64'(tbl[i].elast));
            chk($sformatf("tbl%0d.beat_count", i),  64'(bc_w[0]),  64'(tbl[i].ebc));
            chk($sformatf("tbl%0d.burst_count", i), 64'(brc_w[0]), 64'(tbl[i].ebrc));
            if (tbl[i].ev) chk($sformatf("tbl%0d.m_id", i), 64'(m_id_w[0]), 64'd5);
            advance();
        end

        // Full and backpressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'hB0 + 32'(i), 8'd1, 1'b0, 1'b0);
            chk($sformatf("full.s_ready_after%0d", i + 1), 64'(s_ready_w[0]), 64'(i < 3));
        end
        chk("full.beat_count", 64'(bc_w[0]), 64'd4);
        step(1'b0, 1'b1, 32'hB4, 8'd1, 1'b1, 1'b0);
        chk("full.no_push_when_full", 64'(bc_w[0]), 64'd4);
        drive(1'b0, 1'b1, 32'hB4, 8'd1, 1'b1, 1'b1);
        #1;
        chk("full.no_same_cycle_ready", 64'(s_ready_w[0]), 64'd0);
        advance();
        chk("full.ready_after_pop", 64'(s_ready_w[0]), 64'd1);
        chk("full.count_after_pop", 64'(bc_w[0]), 64'd3);
        step(1'b0, 1'b1, 32'hB4, 8'd1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);

        // Steady push/pop at depth 2; pointers wrap several times
        do_reset();
        step(1'b0, 1'b1, 32'hC0, 8'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hC1, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 32'hC2 + 32'(i), 8'd2, 1'b0, 1'b1);
            chk($sformatf("wrap.beat_count%0d", i), 64'(bc_w[0]), 64'd2);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);

        // Store-and-forward: release waits for the last beat
        do_reset();
        step(1'b0, 1'b1, 32'hD0, 8'd9, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
            chk($sformatf("saf.held%0d", i), 64'(m_valid_w[1]), 64'd0);
        end
        step(1'b0, 1'b1, 32'hD1, 8'd9, 1'b1, 1'b1);
        chk("saf.release_valid", 64'(m_valid_w[1]), 64'd1);
        chk("saf.release_data0", 64'(m_data_w[1]), 64'hD0);
        step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        chk("saf.release_data1", 64'(m_data_w[1]), 64'hD1);
        chk("saf.release_last1", 64'(m_last_w[1]), 64'd1);
        step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        chk("saf.drained", 64'(m_valid_w[1]), 64'd0);

        // Store-and-forward deadlock fallback
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hE0 + 32'(i), 8'd3, 1'b0, 1'b0);
        chk("ovf.not_yet", 64'(saf_w[1]), 64'd0);
        chk("ovf.held_while_full", 64'(m_valid_w[1]), 64'd0);
        step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        chk("ovf.sticky_set", 64'(saf_w[1]), 64'd1);
        chk("ovf.bypass_valid", 64'(m_valid_w[1]), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        chk("ovf.drained", 64'(bc_w[1]), 64'd0);
        step(1'b0, 1'b1, 32'hE4, 8'd3, 1'b1, 1'b1);
        chk("ovf.last_valid", 64'(m_valid_w[1]), 64'd1);
        step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'hE5, 8'd3, 1'b0, 1'b1);
        chk("ovf.bypass_cleared", 64'(m_valid_w[1]), 64'd0);
        chk("ovf.sticky_kept", 64'(saf_w[1]), 64'd1);

        // Reset mid-burst
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hF0 + 32'(i), 8'd4, 1'b0, 1'b0);
        chk("rst.before", 64'(bc_w[0]), 64'd3);
        step(1'b1, 1'b1, 32'hF3, 8'd4, 1'b0, 1'b1);
        chk("rst.beat_count", 64'(bc_w[0]), 64'd0);
        chk("rst.burst_count", 64'(brc_w[0]), 64'd0);
        chk("rst.m_valid", 64'(m_valid_w[0]), 64'd0);
        chk("rst.s_ready_in_reset", 64'(s_ready_w[0]), 64'd0);
        step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        chk("rst.s_ready_after", 64'(s_ready_w[0]), 64'd1);

        // Randomized traffic against the queue model
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) != 0),
                 $urandom(),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
